// File: rtl/writeback_stage.sv
// writeback_stage: registered MEM/WB stage of the MIPS R2000 core.
// It selects the register-file write data from the ALU result, the load data or the link address.
// It extracts sub-word loads (little-endian) with sign or zero extension.
// It suppresses writes to r0 and writes from misaligned loads.
// stall and flush are honoured, and the stage has one cycle of latency.
// Optional feature: define WB_RETIRE_COUNT_EN to add the retire_count port and its counter.
// WIDTH must be 32 or 64.
module writeback_stage #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LINK_OFFSET    = 8,
    parameter int COUNT_WIDTH    = 32,
    localparam int LANE_WIDTH    = $clog2(WIDTH / 8)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_mem,
    input  logic [WIDTH-1:0]          pc_mem,
    input  logic                      rd_mem,
    input  logic [REG_ADDR_WIDTH-1:0] rd_address_mem,
    input  logic [1:0]                src_sel_mem,
    input  logic [WIDTH-1:0]          alu_result_mem,
    input  logic [WIDTH-1:0]          read_data_mem,
    input  logic [1:0]                load_size_mem,
    input  logic                      load_signed_mem,
    input  logic [LANE_WIDTH-1:0]     addr_low_mem,
    output logic                      valid_wb,
    output logic [WIDTH-1:0]          pc_wb,
    output logic                      rd_wb,
    output logic [REG_ADDR_WIDTH-1:0] rd_address_wb,
    output logic [WIDTH-1:0]          rd_data_wb,
    output logic                      misaligned_wb
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0]    retire_count
`endif
);

    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LOAD, SRC_LINK} src_sel_t;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DOUBLE} load_size_t;

    logic [WIDTH-1:0]          shifted;
    logic [WIDTH-1:0]          mask;
    logic                      sign_bit;
    logic                      misaligned_load;
    logic [WIDTH-1:0]          load_value;
    logic                      misaligned;
    logic [WIDTH-1:0]          wb_data;
    logic                      write_en;

    logic                      valid_q;
    logic [WIDTH-1:0]          pc_q;
    logic                      write_q;
    logic [REG_ADDR_WIDTH-1:0] rd_address_q;
    logic [WIDTH-1:0]          data_q;
    logic                      misaligned_q;

    // Load extraction: shift the addressed lane down to bit 0, then mask and extend.
    // Shifting by the full byte lane works for every size, because any lane that is not
    // naturally aligned is flagged misaligned and its data is discarded.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shifted         = read_data_mem >> {addr_low_mem, 3'b000};
        mask            = '1;
        sign_bit        = shifted[WIDTH-1];
        misaligned_load = 1'b0;
        case (load_size_t'(load_size_mem))
            SIZE_BYTE: begin
                mask     = WIDTH'(64'h0000_0000_0000_00FF);
                sign_bit = shifted[7];
            end
            SIZE_HALF: begin
                mask            = WIDTH'(64'h0000_0000_0000_FFFF);
                sign_bit        = shifted[15];
                misaligned_load = addr_low_mem[0];
            end
            SIZE_WORD: begin
                mask            = WIDTH'(64'h0000_0000_FFFF_FFFF);
                sign_bit        = shifted[31];
                misaligned_load = (addr_low_mem[1:0] != 2'b00);
            end
            default: begin
                // A doubleword load is illegal on a 32-bit datapath.
                misaligned_load = (addr_low_mem != '0) || (WIDTH == 32);
            end
        endcase
        load_value = shifted & mask;
        if (load_signed_mem && sign_bit) begin
            load_value = load_value | ~mask;
        end
    end

    // Write-data select and write qualification for the incoming instruction.
    always_comb begin
        misaligned = (src_sel_t'(src_sel_mem) == SRC_LOAD) && misaligned_load;
        wb_data    = '0;
        case (src_sel_t'(src_sel_mem))
            SRC_ALU:  wb_data = alu_result_mem;
            SRC_LOAD: wb_data = misaligned ? '0 : load_value;
            SRC_LINK: wb_data = pc_mem + WIDTH'(LINK_OFFSET);
            default:  wb_data = '0;
        endcase
        write_en = rd_mem && (rd_address_mem != '0) &&
                   (src_sel_t'(src_sel_mem) != SRC_NONE) && !misaligned;
    end

    // Stage register: flush clears the valid bit, even while stalled. A stall holds the contents.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the data fields are reset as well so that every output reads 0 out of reset.
            valid_q      <= 1'b0;
            pc_q         <= '0;
            write_q      <= 1'b0;
            rd_address_q <= '0;
            data_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q <= valid_mem;
            end
            if (!stall) begin
                pc_q         <= pc_mem;
                write_q      <= write_en;
                rd_address_q <= rd_address_mem;
                data_q       <= wb_data;
                misaligned_q <= misaligned;
            end
        end
    end

    // Outputs come from registered state only. stall masks the strobes so that each entry
    // is presented once.
    always_comb begin
        valid_wb      = valid_q && !stall;
        rd_wb         = valid_q && write_q && !stall;
        misaligned_wb = valid_q && misaligned_q && !stall;
        pc_wb         = pc_q;
        rd_address_wb = rd_address_q;
        rd_data_wb    = data_q;
    end

`ifdef WB_RETIRE_COUNT_EN
    // Retire counter: counts every presented instruction, including misaligned ones, and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count <= '0;
        end else if (valid_wb) begin
            retire_count <= retire_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed test of writeback_stage.
// A 32-bit instance and a 64-bit instance share clk, rst, stall and flush.
// The retire_count checks are active only when WB_RETIRE_COUNT_EN is defined.
module tb_writeback_stage;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_ALU  = 2'd1;
    localparam logic [1:0] SEL_LOAD = 2'd2;
    localparam logic [1:0] SEL_LINK = 2'd3;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stall, flush;

    // 32-bit instance signals
    logic        v32, rd32, sgn32;
    logic [31:0] pc32, alu32, rdat32;
    logic [4:0]  ra32;
    logic [1:0]  sel32, size32, lane32;
    logic        o_valid32, o_rd32, o_mis32;
    logic [31:0] o_pc32, o_data32;
    logic [4:0]  o_ra32;
    logic [31:0] count32;

    // 64-bit instance signals
    logic        v64, rd64, sgn64;
    logic [63:0] pc64, alu64, rdat64;
    logic [4:0]  ra64;
    logic [1:0]  sel64, size64;
    logic [2:0]  lane64;
    logic        o_valid64, o_rd64, o_mis64;
    logic [63:0] o_pc64, o_data64;
    logic [4:0]  o_ra64;
    logic [31:0] count64;

    writeback_stage #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_mem(v32), .pc_mem(pc32), .rd_mem(rd32), .rd_address_mem(ra32),
        .src_sel_mem(sel32), .alu_result_mem(alu32), .read_data_mem(rdat32),
        .load_size_mem(size32), .load_signed_mem(sgn32), .addr_low_mem(lane32),
        .valid_wb(o_valid32), .pc_wb(o_pc32), .rd_wb(o_rd32), .rd_address_wb(o_ra32),
        .rd_data_wb(o_data32), .misaligned_wb(o_mis32)
`ifdef WB_RETIRE_COUNT_EN
        , .retire_count(count32)
`endif
    );

    writeback_stage #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_mem(v64), .pc_mem(pc64), .rd_mem(rd64), .rd_address_mem(ra64),
        .src_sel_mem(sel64), .alu_result_mem(alu64), .read_data_mem(rdat64),
        .load_size_mem(size64), .load_signed_mem(sgn64), .addr_low_mem(lane64),
        .valid_wb(o_valid64), .pc_wb(o_pc64), .rd_wb(o_rd64), .rd_address_wb(o_ra64),
        .rd_data_wb(o_data64), .misaligned_wb(o_mis64)
`ifdef WB_RETIRE_COUNT_EN
        , .retire_count(count64)
`endif
    );

`ifndef WB_RETIRE_COUNT_EN
    assign count32 = '0;
    assign count64 = '0;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [31:0] pc, input logic rd, input logic [4:0] ra,
                           input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rdat,
                           input logic [1:0] size, input logic sgn, input logic [1:0] lane);
        v32 = v; pc32 = pc; rd32 = rd; ra32 = ra; sel32 = sel;
        alu32 = alu; rdat32 = rdat; size32 = size; sgn32 = sgn; lane32 = lane;
    endtask

    task automatic drive64(input logic v, input logic [63:0] pc, input logic rd, input logic [4:0] ra,
                           input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] rdat,
                           input logic [1:0] size, input logic sgn, input logic [2:0] lane);
        v64 = v; pc64 = pc; rd64 = rd; ra64 = ra; sel64 = sel;
        alu64 = alu; rdat64 = rdat; size64 = size; sgn64 = sgn; lane64 = lane;
    endtask

    task automatic wb32(input string tag, input logic v, input logic wen, input logic [4:0] ra,
                        input logic [31:0] data, input logic mis);
        check({tag, ".valid"}, 64'(o_valid32), 64'(v));
        check({tag, ".rd_wb"}, 64'(o_rd32), 64'(wen));
        check({tag, ".addr"},  64'(o_ra32), 64'(ra));
        check({tag, ".data"},  64'(o_data32), 64'(data));
        check({tag, ".mis"},   64'(o_mis32), 64'(mis));
    endtask

    task automatic wb64(input string tag, input logic v, input logic wen, input logic [4:0] ra,
                        input logic [63:0] data, input logic mis);
        check({tag, ".valid"}, 64'(o_valid64), 64'(v));
        check({tag, ".rd_wb"}, 64'(o_rd64), 64'(wen));
        check({tag, ".addr"},  64'(o_ra64), 64'(ra));
        check({tag, ".data"},  o_data64, data);
        check({tag, ".mis"},   64'(o_mis64), 64'(mis));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive32(0, 0, 0, 0, SEL_NONE, 0, 0, SZ_B, 0, 0);
        drive64(0, 0, 0, 0, SEL_NONE, 0, 0, SZ_B, 0, 0);
        step();
        step();

        // Reset state
        wb32("rst32", 0, 0, 0, 0, 0);
        check("rst32.pc", 64'(o_pc32), 64'h0);
        wb64("rst64", 0, 0, 0, 0, 0);
`ifdef WB_RETIRE_COUNT_EN
        check("rst32.count", 64'(count32), 64'd0);
`endif
        rst = 1'b0;

        // ---------------- 32-bit instance ----------------
        drive32(1, 32'h100, 1, 5, SEL_ALU, 32'h12345678, 0, SZ_W, 0, 0);
        step();
        wb32("alu", 1, 1, 5, 32'h12345678, 0);
        check("alu.pc", 64'(o_pc32), 64'h100);

        drive32(1, 32'h104, 1, 6, SEL_LOAD, 0, 32'h80FF7F01, SZ_B, 1, 3);
        step();
        wb32("lb3", 1, 1, 6, 32'hFFFFFF80, 0);

        drive32(1, 32'h108, 1, 6, SEL_LOAD, 0, 32'h80FF7F01, SZ_B, 0, 2);
        step();
        wb32("lbu2", 1, 1, 6, 32'h000000FF, 0);

        drive32(1, 32'h10C, 1, 6, SEL_LOAD, 0, 32'h80FF7F01, SZ_H, 1, 2);
        step();
        wb32("lh2", 1, 1, 6, 32'hFFFF80FF, 0);

        drive32(1, 32'h110, 1, 6, SEL_LOAD, 0, 32'h80FF7F01, SZ_H, 0, 0);
        step();
        wb32("lhu0", 1, 1, 6, 32'h00007F01, 0);

        drive32(1, 32'h114, 1, 6, SEL_LOAD, 0, 32'h80FF7F01, SZ_W, 1, 1);
        step();
        wb32("lw1_mis", 1, 0, 6, 32'h0, 1);

        drive32(1, 32'h118, 1, 6, SEL_LOAD, 0, 32'h80FF7F01, SZ_D, 0, 0);
        step();
        wb32("ld32_illegal", 1, 0, 6, 32'h0, 1);

        drive32(1, 32'h11C, 1, 0, SEL_ALU, 32'hDEADBEEF, 0, SZ_W, 0, 0);
        step();
        wb32("alu_r0", 1, 0, 0, 32'hDEADBEEF, 0);

        drive32(1, 32'hFFFFFFFC, 1, 31, SEL_LINK, 0, 0, SZ_W, 0, 0);
        step();
        wb32("link_wrap", 1, 1, 31, 32'h00000004, 0);

        drive32(1, 32'h120, 1, 4, SEL_NONE, 32'h55, 0, SZ_W, 0, 0);
        step();
        wb32("sel_none", 1, 0, 4, 32'h0, 0);

        v32 = 1'b0;
        step();
        check("idle.valid", 64'(o_valid32), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
        check("count_after10", 64'(count32), 64'd10);
`endif

        // Three stall cycles, then release. The input changes during the stall must be ignored.
        drive32(1, 32'h200, 1, 7, SEL_ALU, 32'hAAAA5555, 0, SZ_W, 0, 0);
        step();
        stall = 1'b1;
        drive32(1, 32'h300, 1, 9, SEL_ALU, 32'h11111111, 0, SZ_W, 0, 0);
        #1;
        check("stall1.rd_wb", 64'(o_rd32), 64'd0);
        check("stall1.valid", 64'(o_valid32), 64'd0);
        step();
        check("stall2.rd_wb", 64'(o_rd32), 64'd0);
        check("stall2.addr", 64'(o_ra32), 64'd7);
        step();
        check("stall3.rd_wb", 64'(o_rd32), 64'd0);
        stall = 1'b0;
        v32 = 1'b0;
        #1;
        wb32("release", 1, 1, 7, 32'hAAAA5555, 0);
        step();
        check("post_release.rd_wb", 64'(o_rd32), 64'd0);
        check("post_release.valid", 64'(o_valid32), 64'd0);

        // A flush during a stall must produce no pulse.
        drive32(1, 32'h400, 1, 8, SEL_ALU, 32'h5, 0, SZ_W, 0, 0);
        step();
        stall = 1'b1;
        flush = 1'b1;
        v32 = 1'b0;
        #1;
        check("flush_stall.rd_wb", 64'(o_rd32), 64'd0);
        step();
        flush = 1'b0;
        step();
        stall = 1'b0;
        #1;
        check("flushed.valid", 64'(o_valid32), 64'd0);
        check("flushed.rd_wb", 64'(o_rd32), 64'd0);
        step();
`ifdef WB_RETIRE_COUNT_EN
        check("count_after_stall", 64'(count32), 64'd11);
`endif

        // Reset while a valid entry is in the stage
        drive32(1, 32'h500, 1, 3, SEL_ALU, 32'hCAFE, 0, SZ_W, 0, 0);
        step();
        check("pre_rst.valid", 64'(o_valid32), 64'd1);
        rst = 1'b1;
        step();
        wb32("mid_rst", 0, 0, 0, 32'h0, 0);
        check("mid_rst.pc", 64'(o_pc32), 64'h0);
`ifdef WB_RETIRE_COUNT_EN
        check("mid_rst.count", 64'(count32), 64'd0);
`endif
        rst = 1'b0;
        v32 = 1'b0;

        // ---------------- 64-bit instance ----------------
        drive64(1, 64'h1000, 1, 10, SEL_ALU, 64'h0123456789ABCDEF, 0, SZ_D, 0, 0);
        step();
        wb64("alu64", 1, 1, 10, 64'h0123456789ABCDEF, 0);
        check("alu64.pc", o_pc64, 64'h1000);

        drive64(1, 64'h1008, 1, 11, SEL_LOAD, 0, 64'h8000000012345678, SZ_D, 1, 0);
        step();
        wb64("ld0", 1, 1, 11, 64'h8000000012345678, 0);

        drive64(1, 64'h1010, 1, 11, SEL_LOAD, 0, 64'hDEADBEEF12345678, SZ_W, 1, 4);
        step();
        wb64("lw4", 1, 1, 11, 64'hFFFFFFFFDEADBEEF, 0);

        drive64(1, 64'h1018, 1, 11, SEL_LOAD, 0, 64'hDEADBEEF12345678, SZ_W, 0, 4);
        step();
        wb64("lwu4", 1, 1, 11, 64'h00000000DEADBEEF, 0);

        drive64(1, 64'h1020, 1, 11, SEL_LOAD, 0, 64'hDEADBEEF12345678, SZ_W, 1, 0);
        step();
        wb64("lw0", 1, 1, 11, 64'h0000000012345678, 0);

        drive64(1, 64'h1028, 1, 12, SEL_LOAD, 0, 64'h80FF7F0100000000, SZ_B, 1, 7);
        step();
        wb64("lb7", 1, 1, 12, 64'hFFFFFFFFFFFFFF80, 0);

        drive64(1, 64'h1030, 1, 12, SEL_LOAD, 0, 64'h80FF7F0100000000, SZ_H, 1, 6);
        step();
        wb64("lh6", 1, 1, 12, 64'hFFFFFFFFFFFF80FF, 0);

        drive64(1, 64'h1038, 1, 12, SEL_LOAD, 0, 64'h80FF7F0100000000, SZ_D, 0, 4);
        step();
        wb64("ld4_mis", 1, 0, 12, 64'h0, 1);

        drive64(1, 64'h1040, 1, 12, SEL_LOAD, 0, 64'h80FF7F0100000000, SZ_W, 0, 2);
        step();
        wb64("lw2_mis", 1, 0, 12, 64'h0, 1);

        drive64(1, 64'hFFFFFFFFFFFFFFFC, 1, 31, SEL_LINK, 0, 0, SZ_D, 0, 0);
        step();
        wb64("link64_wrap", 1, 1, 31, 64'h4, 0);

        drive64(1, 64'h1048, 1, 0, SEL_ALU, 64'h77, 0, SZ_D, 0, 0);
        step();
        wb64("alu64_r0", 1, 0, 0, 64'h77, 0);

        v64 = 1'b0;
        step();
`ifdef WB_RETIRE_COUNT_EN
        check("count64_after11", 64'(count64), 64'd11);
`endif

        drive64(1, 64'h2000, 1, 13, SEL_ALU, 64'hF0F0F0F0F0F0F0F0, 0, SZ_D, 0, 0);
        step();
        stall = 1'b1;
        v64 = 1'b0;
        #1;
        check("stall64.rd_wb", 64'(o_rd64), 64'd0);
        step();
        stall = 1'b0;
        #1;
        wb64("release64", 1, 1, 13, 64'hF0F0F0F0F0F0F0F0, 0);
        step();
        check("post_release64.rd_wb", 64'(o_rd64), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
        check("count64_after_stall", 64'(count64), 64'd12);
`endif

        drive64(1, 64'h3000, 1, 14, SEL_ALU, 64'h1234, 0, SZ_D, 0, 0);
        step();
        rst = 1'b1;
        step();
        wb64("mid_rst64", 0, 0, 0, 64'h0, 0);
        check("mid_rst64.pc", o_pc64, 64'h0);
`ifdef WB_RETIRE_COUNT_EN
        check("mid_rst64.count", 64'(count64), 64'd0);
`endif
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
